sr_write_verify_seq: RTL and testbench

//  Sequencer in front of the shift-register write/readback engine.

---
 rtl/sr_write_verify_seq.sv | 214 +++++++++++++++++++++
 tb/tb_sr_write_verify_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_write_verify_seq.sv
// Write-twice/verify sequencer for the SR chain engine: program, read back, retry, time out, report.
// Optional SR_SEQ_MISMATCH_COUNT_EN adds a registered popcount of the last compare (mismatch_bits).
module sr_write_verify_seq #(
    parameter int WIDTH       = 170,
    parameter int TO_WIDTH    = 16,
    parameter int RETRY_WIDTH = 4,
    localparam int MB_W       = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [WIDTH-1:0]       cfg_data,
    input  logic [RETRY_WIDTH-1:0] max_retry,
    input  logic [TO_WIDTH-1:0]    timeout,
    output logic                   sr_start,
    output logic [WIDTH-1:0]       sr_din,
    input  logic                   sr_done,
    input  logic [WIDTH-1:0]       sr_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   ok,
    output logic [1:0]             err_code,
    output logic [RETRY_WIDTH-1:0] attempts
`ifdef SR_SEQ_MISMATCH_COUNT_EN
    ,
    output logic [MB_W-1:0]        mismatch_bits
`endif
);

    typedef enum logic [2:0] {
        IDLE, P1_GO, P1_WAIT, P2_GO, P2_WAIT, CHECK, FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       word_q, word_d;
    logic [WIDTH-1:0]       cap_q, cap_d;
    logic [RETRY_WIDTH-1:0] max_retry_q, max_retry_d;
    logic [RETRY_WIDTH-1:0] attempts_q, attempts_d;
    logic [TO_WIDTH-1:0]    timeout_q, timeout_d;
    logic [TO_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   sr_start_q, sr_start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ok_q, ok_d;
    logic [1:0]             err_q, err_d;

    logic                   expired;
    logic                   retry_ok;
    logic                   chk_go;
    logic                   chk_match;
    logic [TO_WIDTH-1:0]    cnt_sat;

    // The count is the number of WAIT cycles already spent; expiry fires on the cycle that reaches timeout.
    assign expired  = (timeout_q != '0) &&
                      (({1'b0, cnt_q} + (TO_WIDTH + 1)'(1)) >= {1'b0, timeout_q});
    assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_q + TO_WIDTH'(1);
    assign retry_ok = (attempts_q <= max_retry_q) && !(&attempts_q);

`ifdef SR_SEQ_MISMATCH_COUNT_EN
    logic [MB_W-1:0] mism_q, mism_d;
    logic            chk2_q, chk2_d;

    function automatic logic [MB_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [MB_W-1:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) s = s + MB_W'(v[i]);
        return s;
    endfunction

    // First CHECK cycle registers the popcount, second one decides on it.
    assign chk_go    = chk2_q;
    assign chk_match = (mism_q == '0);
    assign mismatch_bits = mism_q;
`else
    assign chk_go    = 1'b1;
    assign chk_match = (cap_q == word_q);
`endif

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cap_d       = cap_q;
        max_retry_d = max_retry_q;
        attempts_d  = attempts_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ok_d        = ok_q;
        err_d       = err_q;
        sr_start_d  = 1'b0;
        done_d      = 1'b0;
`ifdef SR_SEQ_MISMATCH_COUNT_EN
        mism_d      = mism_q;
        chk2_d      = chk2_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    word_d      = cfg_data;
                    max_retry_d = max_retry;
                    timeout_d   = timeout;
                    attempts_d  = RETRY_WIDTH'(1);
                    ok_d        = 1'b0;
                    err_d       = ERR_NONE;
                    busy_d      = 1'b1;
                    sr_start_d  = 1'b1;
                    state_d     = P1_GO;
                end
            end
            P1_GO: begin
                cnt_d   = '0;
                state_d = P1_WAIT;
            end
            P2_GO: begin
                cnt_d   = '0;
                state_d = P2_WAIT;
            end
            P1_WAIT, P2_WAIT: begin
                cnt_d = cnt_sat;
                if (sr_done) begin
                    if (state_q == P1_WAIT) begin
                        sr_start_d = 1'b1;
                        state_d    = P2_GO;
                    end else begin
                        cap_d   = sr_dout;
                        state_d = CHECK;
                    end
                end else if (expired) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            CHECK: begin
`ifdef SR_SEQ_MISMATCH_COUNT_EN
                chk2_d = !chk2_q;
                if (!chk2_q) mism_d = popcount(cap_q ^ word_q);
`endif
                if (chk_go) begin
                    if (chk_match) begin
                        ok_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else if (retry_ok) begin
                        // Chain already holds the word, so only the verify pass is repeated.
                        attempts_d = attempts_q + RETRY_WIDTH'(1);
                        sr_start_d = 1'b1;
                        state_d    = P2_GO;
                    end else begin
                        err_d   = ERR_MISMATCH;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            cap_q       <= '0;
            max_retry_q <= '0;
            attempts_q  <= '0;
            timeout_q   <= '0;
            cnt_q       <= '0;
            sr_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= ERR_NONE;
`ifdef SR_SEQ_MISMATCH_COUNT_EN
            mism_q      <= '0;
            chk2_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cap_q       <= cap_d;
            max_retry_q <= max_retry_d;
            attempts_q  <= attempts_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            sr_start_q  <= sr_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
`ifdef SR_SEQ_MISMATCH_COUNT_EN
            mism_q      <= mism_d;
            chk2_q      <= chk2_d;
`endif
        end
    end

    assign sr_start = sr_start_q;
    assign sr_din   = word_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ok       = ok_q;
    assign err_code = err_q;
    assign attempts = attempts_q;

endmodule

// File: tb/tb_sr_write_verify_seq.sv
// Bench for sr_write_verify_seq: SR engine model, directed table, random runs against a pass-level model.
module tb_sr_write_verify_seq;
    localparam int W  = 170;
    localparam int TW = 16;
    localparam int RW = 4;
`ifdef SR_SEQ_MISMATCH_COUNT_EN
    localparam int CHK = 2;
    localparam int MBW = $clog2(W + 1);
`else
    localparam int CHK = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic [W-1:0]  cfg_data = '0;
    logic [RW-1:0] max_retry = '0;
    logic [TW-1:0] timeout = '0;
    logic          sr_start;
    logic [W-1:0]  sr_din;
    logic          sr_done;
    logic [W-1:0]  sr_dout;
    logic          busy, done, ok;
    logic [1:0]    err_code;
    logic [RW-1:0] attempts;
`ifdef SR_SEQ_MISMATCH_COUNT_EN
    logic [MBW-1:0] mismatch_bits;
`endif

    sr_write_verify_seq #(.WIDTH(W), .TO_WIDTH(TW), .RETRY_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
        .max_retry(max_retry), .timeout(timeout), .sr_start(sr_start), .sr_din(sr_din),
        .sr_done(sr_done), .sr_dout(sr_dout), .busy(busy), .done(done), .ok(ok),
        .err_code(err_code), .attempts(attempts)
`ifdef SR_SEQ_MISMATCH_COUNT_EN
        , .mismatch_bits(mismatch_bits)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine model: sr_done arrives d cycles after sr_start; P1 returns the old chain,
    // verify passes return the chain (the written word) xor a per-pass corruption mask.
    int           eng_d1 = 1, eng_d2 = 1, eng_cnt = 0, pass_cnt = 0, n_starts = 0, first_start_cyc = 0;
    bit           eng_stall = 0, eng_stuck = 0;
    logic [W-1:0] chain = '0, din_lat = '0;
    logic [W-1:0] vmask [16];

    initial begin
        sr_done = 1'b0;
        sr_dout = '0;
        forever begin
            @(negedge clk);
            sr_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    sr_done = 1'b1;
                    if (pass_cnt == 0) sr_dout = chain;
                    else if (eng_stuck) sr_dout = '1;
                    else sr_dout = chain ^ vmask[(pass_cnt - 1) % 16];
                    chain = din_lat;
                    pass_cnt++;
                end
            end
            if (sr_start === 1'b1) begin
                n_starts++;
                if (n_starts == 1) first_start_cyc = cyc;
                din_lat = sr_din;
                if (!eng_stall) eng_cnt = (n_starts == 1) ? eng_d1 : eng_d2;
            end
        end
    end

    function automatic logic [W-1:0] rand_word();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_mask();
        logic [W-1:0] m;
        m = '0;
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) m[$urandom_range(0, W - 1)] = 1'b1;
        end
        return m;
    endfunction

    // Pass-level reference: walk the passes, add up cycles, decide the outcome.
    int model_mism = 0;
    task automatic ref_model(input logic [W-1:0] w, input int maxr, input int to, input int d1,
                             input int d2, input bit stuck, output bit e_ok, output int e_err,
                             output int e_att, output int e_st, output int e_lat);
        logic [W-1:0] rb;
        e_ok = 0; e_err = 0; e_att = 1; e_st = 1; e_lat = 1;
        if (to != 0 && to < d1) begin e_lat += 1 + to; e_err = 2; return; end
        e_lat += 1 + d1;
        forever begin
            e_st++;
            if (to != 0 && to < d2) begin e_lat += 1 + to; e_err = 2; return; end
            e_lat += 1 + d2 + CHK;
            rb = stuck ? '1 : (w ^ vmask[(e_att - 1) % 16]);
            model_mism = $countones(rb ^ w);
            if (model_mism == 0) begin e_ok = 1; return; end
            if (e_att <= maxr && e_att < (1 << RW) - 1) e_att++;
            else begin e_err = 1; return; end
        end
    endtask

    int t_acc;
    bit r_got, r_ok;
    int r_err, r_att, r_lat, r_done_cyc;
    logic [W-1:0] r_din;

    task automatic start_txn(input logic [W-1:0] w, input int maxr, input int to, input int d1, input int d2);
        @(negedge clk);
        eng_d1 = d1; eng_d2 = d2; eng_cnt = 0; pass_cnt = 0; n_starts = 0;
        cfg_data = w; max_retry = RW'(maxr); timeout = TW'(to); cfg_start = 1'b1;
        t_acc = cyc;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic run_txn(input logic [W-1:0] w, input int maxr, input int to, input int d1,
                           input int d2, input bit spam);
        start_txn(w, maxr, to, d1, d2);
        r_got = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                r_got = 1; r_ok = ok; r_err = int'(err_code); r_att = int'(attempts);
                r_lat = cyc - t_acc; r_done_cyc = cyc; r_din = sr_din;
                break;
            end
            if (spam) begin
                cfg_start = 1'($urandom_range(0, 1));
                cfg_data  = rand_word();
                max_retry = RW'($urandom);
                timeout   = TW'($urandom_range(1, 3));
            end
            @(negedge clk);
        end
        cfg_start = 1'b0;
        cfg_data  = w;
    endtask

    typedef struct {
        int d1, d2, to, maxr, mode;
        bit e_ok;
        int e_err, e_att, e_st, e_lat, e_mism;
    } vec_t;

    logic [W-1:0] good_w;
    vec_t tbl [7];

    initial begin
        bit e_ok;
        int e_err, e_att, e_st, e_lat, dn, st;
        good_w = {2'b10, {41{4'hA}}, 4'h5};
        foreach (vmask[k]) vmask[k] = '0;
        // mode: 0 clean readback, 1 bit 0 flipped on first verify only, 2 readback stuck at ones
        tbl[0] = '{3, 3, 0,   0, 0, 1, 0, 1, 2, 9 + CHK,         0};
        tbl[1] = '{2, 2, 0,   2, 1, 1, 0, 2, 3, 10 + 2 * CHK,    0};
        tbl[2] = '{1, 1, 0,   1, 2, 0, 1, 2, 3, 7 + 2 * CHK,     85};
        tbl[3] = '{4, 4, 4,   0, 0, 1, 0, 1, 2, 11 + CHK,        0};
        tbl[4] = '{5, 5, 4,   0, 0, 0, 2, 1, 1, 6,               0};
        tbl[5] = '{2, 6, 4,   2, 0, 0, 2, 1, 2, 9,               0};
        tbl[6] = '{1, 1, 0,   0, 1, 0, 1, 1, 2, 5 + CHK,         1};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sr_start", 256'(sr_start), 256'(0));
        check("rst_sr_din", 256'(sr_din), 256'(0));
        check("rst_busy_done", 256'({busy, done, ok}), 256'(0));
        check("rst_err_att", 256'({err_code, attempts}), 256'(0));
`ifdef SR_SEQ_MISMATCH_COUNT_EN
        check("rst_mism", 256'(mismatch_bits), 256'(0));
`endif
        rst = 1'b1;

        foreach (tbl[i]) begin
            foreach (vmask[k]) vmask[k] = '0;
            if (tbl[i].mode == 1) vmask[0] = W'(1);
            eng_stuck = (tbl[i].mode == 2);
            run_txn(good_w, tbl[i].maxr, tbl[i].to, tbl[i].d1, tbl[i].d2, 0);
            check($sformatf("t%0d_done", i), 256'(r_got), 256'(1));
            check($sformatf("t%0d_ok", i), 256'(r_ok), 256'(tbl[i].e_ok));
            check($sformatf("t%0d_err", i), 256'(r_err), 256'(tbl[i].e_err));
            check($sformatf("t%0d_att", i), 256'(r_att), 256'(tbl[i].e_att));
            check($sformatf("t%0d_starts", i), 256'(n_starts), 256'(tbl[i].e_st));
            check($sformatf("t%0d_lat", i), 256'(r_lat), 256'(tbl[i].e_lat));
            check($sformatf("t%0d_din", i), 256'(r_din), 256'(good_w));
`ifdef SR_SEQ_MISMATCH_COUNT_EN
            check($sformatf("t%0d_mism", i), 256'(mismatch_bits), 256'(tbl[i].e_mism));
`endif
            @(negedge clk);
            check($sformatf("t%0d_pulse", i), 256'({done, busy}), 256'(0));
        end
        eng_stuck = 0;
        model_mism = 1;

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] w;
            int d1, d2, to, maxr;
            bit stuck;
            w = rand_word();
            d1 = $urandom_range(1, 6); d2 = $urandom_range(1, 6);
            to = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8));
            maxr = $urandom_range(0, 4);
            stuck = ($urandom_range(0, 7) == 0);
            foreach (vmask[k]) vmask[k] = rand_mask();
            eng_stuck = stuck;
            ref_model(w, maxr, to, d1, d2, stuck, e_ok, e_err, e_att, e_st, e_lat);
            run_txn(w, maxr, to, d1, d2, n % 4 == 3);
            check($sformatf("r%0d_done", n), 256'(r_got), 256'(1));
            check($sformatf("r%0d_status", n), 256'({r_ok, 2'(r_err)}), 256'({e_ok, 2'(e_err)}));
            check($sformatf("r%0d_att", n), 256'(r_att), 256'(e_att));
            check($sformatf("r%0d_starts", n), 256'(n_starts), 256'(e_st));
            check($sformatf("r%0d_lat", n), 256'(r_lat), 256'(e_lat));
            check($sformatf("r%0d_din", n), 256'(r_din), 256'(w));
`ifdef SR_SEQ_MISMATCH_COUNT_EN
            check($sformatf("r%0d_mism", n), 256'(mismatch_bits), 256'(model_mism));
`endif
        end
        eng_stuck = 0;
        foreach (vmask[k]) vmask[k] = '0;

        // Stalled engine, timeout=100: done lands 101 cycles after the P1_GO cycle.
        eng_stall = 1;
        run_txn(good_w, 3, 100, 1, 1, 0);
        check("to100_done", 256'(r_got), 256'(1));
        check("to100_err", 256'({r_ok, 2'(r_err), RW'(r_att)}), 256'({1'b0, 2'd2, RW'(1)}));
        check("to100_lat", 256'(r_done_cyc - first_start_cyc), 256'(101));
        check("to100_starts", 256'(n_starts), 256'(1));

        // Stalled engine, timeout=0: waits forever.
        start_txn(good_w, 0, 0, 1, 1);
        dn = 0;
        repeat (300) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("to0_busy", 256'(busy), 256'(1));
        check("to0_nodone", 256'(dn), 256'(0));
        rst = 1'b0;
        #1 check("to0_rst", 256'({busy, sr_start, done}), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        eng_stall = 0;

        // Reset during P2_WAIT, then the abandoned pass's late sr_done.
        start_txn(good_w, 0, 0, 2, 30);
        for (int i = 0; i < 100 && n_starts < 2; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("p2w_busy", 256'({busy, n_starts == 2}), 256'(2'b11));
        rst = 1'b0;
        #1;
        check("p2w_rst_async", 256'({sr_start, busy, done, ok, err_code, attempts}), 256'(0));
        @(posedge clk);
        #1;
        check("p2w_rst_edge", 256'({sr_start, busy, done, ok, err_code, attempts}), 256'(0));
        check("p2w_rst_din", 256'(sr_din), 256'(0));
`ifdef SR_SEQ_MISMATCH_COUNT_EN
        check("p2w_rst_mism", 256'(mismatch_bits), 256'(0));
`endif
        @(negedge clk);
        rst = 1'b1;
        dn = 0; st = 0;
        repeat (45) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (sr_start === 1'b1) st++;
        end
        check("late_done_ignored", 256'({8'(dn), 8'(st), busy, ok}), 256'(0));
        run_txn(good_w, 0, 0, 2, 2, 0);
        check("fresh_done", 256'(r_got), 256'(1));
        check("fresh_ok", 256'({r_ok, 2'(r_err), RW'(r_att)}), 256'({1'b1, 2'd0, RW'(1)}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
